chan_scan_seq: RTL and testbench

CHAN_SCAN_SEQ -- requirements
Module: chan_scan_seq

---
 rtl/chan_scan_seq.sv | 181 ++++++++++++++++++
 tb/tb_chan_scan_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_scan_seq.sv
// ---------------------------------------------------------------------------
// chan_scan_seq
//
// Channel scan sequencer for a 3-to-8 select decoder. After a start request
// it walks channels 0..7 once, skipping the ones not enabled in the latched
// mask. For each enabled channel it holds the select S with en high for
// dwell+1 cycles. done pulses for one cycle at the end of the pass.
//
// Optional build macro:
//   CHAN_SCAN_CONT_EN - when defined, the scan restarts from channel 0 after
//                       every done pulse, reusing the latched mask/dwell,
//                       until abort or reset. A start with an empty mask
//                       still returns to IDLE after its done pulse.
//
// Parameters:
//   DWELL_W  width of the dwell-count input (default 4)
//
// Ports:
//   clk    in   rising-edge clock for all state
//   rst_n  in   asynchronous active-low reset
//   start  in   request one scan (sampled only in IDLE)
//   abort  in   terminate the scan (sampled in SEEK and DWELL)
//   mask   in   [7:0] per-channel enable, bit i selects channel i
//   dwell  in   [DWELL_W-1:0] hold time per channel, in cycles minus 1
//   S      out  [2:0] channel select to the decoder
//   en     out  select valid; gates the decoder outputs downstream
//   busy   out  high while in SEEK or DWELL
//   done   out  one-cycle pulse at the end of a pass
// ---------------------------------------------------------------------------
module chan_scan_seq #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         S,
    output logic               en,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [2:0]         ptr, ptr_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [7:0]         mask_q, mask_q_n;
    logic [DWELL_W-1:0] dwell_q, dwell_q_n;
    logic [2:0]         s_n;
    logic               en_n;
    logic               busy_n;
    logic               done_n;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            cnt     <= '0;
            mask_q  <= 8'h00;
            dwell_q <= '0;
            S       <= 3'd0;
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            mask_q  <= mask_q_n;
            dwell_q <= dwell_q_n;
            S       <= s_n;
            en      <= en_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Next-state and next-output decode. Outputs are computed for the state
    // being entered so that every output comes straight from a flop.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        mask_q_n  = mask_q;
        dwell_q_n = dwell_q;
        s_n       = S;      // select holds its last value unless re-loaded
        en_n      = 1'b0;
        busy_n    = 1'b0;
        done_n    = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    mask_q_n  = mask;
                    dwell_q_n = dwell;
                    ptr_n     = 3'd0;
                    cnt_n     = '0;
                    if (mask != 8'h00) begin
                        state_n = SEEK;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end
            end

            SEEK: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (mask_q[ptr]) begin
                    // S is loaded only here, on the edge where en rises from
                    // 0, so it never moves while the decoder is enabled.
                    state_n = DWELL;
                    cnt_n   = '0;
                    s_n     = ptr;
                    en_n    = 1'b1;
                    busy_n  = 1'b1;
                end else if (ptr == 3'd7) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    ptr_n  = ptr + 3'd1;
                    busy_n = 1'b1;
                end
            end

            DWELL: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (cnt == dwell_q) begin
                    // dwell+1 cycles elapsed; the ptr==7 test keeps ptr from
                    // wrapping within a pass.
                    if (ptr == 3'd7) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = SEEK;
                        ptr_n   = ptr + 3'd1;
                        busy_n  = 1'b1;
                    end
                end else begin
                    cnt_n  = cnt + 1'b1;
                    en_n   = 1'b1;
                    busy_n = 1'b1;
                end
            end

            DONE: begin
`ifdef CHAN_SCAN_CONT_EN
                // Re-scan with the latched settings; an empty mask means the
                // pass came from a start with nothing to scan, so stop.
                if (mask_q != 8'h00) begin
                    state_n = SEEK;
                    ptr_n   = 3'd0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                end else begin
                    state_n = IDLE;
                end
`else
                state_n = IDLE;
`endif
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_chan_scan_seq.sv
// ---------------------------------------------------------------------------
// tb_chan_scan_seq
//
// Directed bench for chan_scan_seq. Each cycle's expectation is packed as
// {busy, done, en, S} and compared one tick after the rising edge.
// ---------------------------------------------------------------------------
module tb_chan_scan_seq;

    localparam int DWELL_W = 4;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         S;
    logic               en;
    logic               busy;
    logic               done;

    int n_checks;
    int n_errors;

    chan_scan_seq #(.DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .mask  (mask),
        .dwell (dwell),
        .S     (S),
        .en    (en),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] obs();
        return {26'd0, busy, done, en, S};
    endfunction

    function automatic logic [31:0] pk(input logic b, input logic d,
                                       input logic e, input logic [2:0] s);
        return {26'd0, b, d, e, s};
    endfunction

    // Advance one clock and compare {busy,done,en,S}
    task automatic step(input string tag, input logic b, input logic d,
                        input logic e, input logic [2:0] s);
        tick();
        check(tag, obs(), pk(b, d, e, s));
    endtask

    initial begin
        int waited;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mask  = 8'h00;
        dwell = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #1 check("reset_outputs", obs(), pk(0, 0, 0, 3'd0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // mask 81, dwell 2: first start right after reset release
        mask = 8'h81; dwell = 4'd2; start = 1'b1;
        step("s81_seek0", 1, 0, 0, 3'd0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) step("s81_dwell0", 1, 0, 1, 3'd0);
        for (int i = 0; i < 7; i++) step("s81_seek", 1, 0, 0, 3'd0);
        for (int i = 0; i < 3; i++) step("s81_dwell7", 1, 0, 1, 3'd7);
        step("s81_done", 0, 1, 0, 3'd7);
`ifdef CHAN_SCAN_CONT_EN
        step("s81_rescan", 1, 0, 0, 3'd7);
        abort = 1'b1;
        step("s81_abort", 0, 0, 0, 3'd7);
        abort = 1'b0;
`else
        step("s81_idle", 0, 0, 0, 3'd7);
`endif

        // mask FF, dwell 0: 1-cycle en per channel, 1 SEEK cycle between
        mask = 8'hFF; dwell = 4'd0; start = 1'b1;
        step("sff_seek0", 1, 0, 0, 3'd7);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step("sff_dwell", 1, 0, 1, 3'(k));
            if (k < 7) step("sff_seek", 1, 0, 0, 3'(k));
        end
        step("sff_done", 0, 1, 0, 3'd7);
`ifdef CHAN_SCAN_CONT_EN
        abort = 1'b1;
        step("sff_rescan", 1, 0, 0, 3'd7);
        step("sff_abort", 0, 0, 0, 3'd7);
        abort = 1'b0;
`else
        step("sff_idle", 0, 0, 0, 3'd7);
`endif

        // mask 00: straight to DONE, then IDLE (also in continuous mode)
        mask = 8'h00; dwell = 4'd3; start = 1'b1;
        step("s00_done", 0, 1, 0, 3'd7);
        start = 1'b0;
        step("s00_idle", 0, 0, 0, 3'd7);
        step("s00_idle2", 0, 0, 0, 3'd7);

        // mask 10, dwell 5: input changes and a start mid-scan are ignored;
        // abort in the 3rd dwell cycle
        mask = 8'h10; dwell = 4'd5; start = 1'b1;
        step("s10_seek0", 1, 0, 0, 3'd7);
        start = 1'b0; mask = 8'h00; dwell = 4'd0;
        step("s10_seek1", 1, 0, 0, 3'd7);
        start = 1'b1;
        step("s10_seek2", 1, 0, 0, 3'd7);
        start = 1'b0;
        step("s10_seek3", 1, 0, 0, 3'd7);
        step("s10_seek4", 1, 0, 0, 3'd7);
        step("s10_dwell1", 1, 0, 1, 3'd4);
        step("s10_dwell2", 1, 0, 1, 3'd4);
        step("s10_dwell3", 1, 0, 1, 3'd4);
        abort = 1'b1;
        step("s10_abort", 0, 0, 0, 3'd4);
        abort = 1'b0;
        step("s10_nodone", 0, 0, 0, 3'd4);
        step("s10_idle", 0, 0, 0, 3'd4);

        // abort held in IDLE does not block start; it then wins in SEEK
        mask = 8'h01; dwell = 4'd0; start = 1'b1; abort = 1'b1;
        step("ab_idle_start", 1, 0, 0, 3'd4);
        start = 1'b0;
        step("ab_seek", 0, 0, 0, 3'd4);
        abort = 1'b0;

        // abort beats end of pass in the last dwell cycle of channel 7
        mask = 8'h80; dwell = 4'd0; start = 1'b1;
        step("ab7_seek0", 1, 0, 0, 3'd4);
        start = 1'b0;
        for (int i = 0; i < 7; i++) step("ab7_seek", 1, 0, 0, 3'd4);
        step("ab7_dwell", 1, 0, 1, 3'd7);
        abort = 1'b1;
        step("ab7_abort", 0, 0, 0, 3'd7);
        abort = 1'b0;
        step("ab7_nodone", 0, 0, 0, 3'd7);

        // maximum dwell: 16 cycles of en on channel 0
        mask = 8'h01; dwell = 4'hF; start = 1'b1;
        step("dmax_seek0", 1, 0, 0, 3'd7);
        start = 1'b0;
        for (int i = 0; i < 16; i++) step("dmax_dwell", 1, 0, 1, 3'd0);
        step("dmax_seek1", 1, 0, 0, 3'd0);
        abort = 1'b1;
        step("dmax_abort", 0, 0, 0, 3'd0);
        abort = 1'b0;

        // asynchronous reset mid-DWELL, then a normal scan after release
        mask = 8'h01; dwell = 4'd3; start = 1'b1;
        step("rst_seek0", 1, 0, 0, 3'd0);
        start = 1'b0;
        mask = 8'h04;
        step("rst_dwell", 1, 0, 1, 3'd0);
        mask = 8'h01;
        #2 rst_n = 1'b0;
        #1 check("rst_async", obs(), pk(0, 0, 0, 3'd0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        mask = 8'h01; dwell = 4'd0; start = 1'b1;
        step("post_seek0", 1, 0, 0, 3'd0);
        start = 1'b0;
        step("post_dwell", 1, 0, 1, 3'd0);
        step("post_seek1", 1, 0, 0, 3'd0);
        waited = 0;
        while (!done && waited < 20) begin
            tick();
            waited++;
        end
        check("post_done_lat", 32'(waited), 32'd7);
        check("post_done_bus", obs(), pk(0, 1, 0, 3'd0));
`ifdef CHAN_SCAN_CONT_EN
        abort = 1'b1;
        step("post_rescan", 1, 0, 0, 3'd0);
        step("post_abort", 0, 0, 0, 3'd0);
        abort = 1'b0;
`else
        step("post_idle", 0, 0, 0, 3'd0);
`endif

        // mask 02, dwell 1: single pass by default, repeating when continuous
        mask = 8'h02; dwell = 4'd1; start = 1'b1;
        step("s02_seek0", 1, 0, 0, 3'd0);
        start = 1'b0;
`ifdef CHAN_SCAN_CONT_EN
        for (int p = 0; p < 3; p++) begin
            if (p > 0) step("s02_seek0", 1, 0, 0, 3'd1);
            step("s02_seek1", 1, 0, 0, p == 0 ? 3'd0 : 3'd1);
            step("s02_dwell", 1, 0, 1, 3'd1);
            step("s02_dwell", 1, 0, 1, 3'd1);
            for (int i = 0; i < 6; i++) step("s02_seek", 1, 0, 0, 3'd1);
            step("s02_done", 0, 1, 0, 3'd1);
        end
        step("s02_again", 1, 0, 0, 3'd1);
        abort = 1'b1;
        step("s02_abort", 0, 0, 0, 3'd1);
        abort = 1'b0;
        step("s02_idle", 0, 0, 0, 3'd1);
`else
        step("s02_seek1", 1, 0, 0, 3'd0);
        step("s02_dwell", 1, 0, 1, 3'd1);
        step("s02_dwell", 1, 0, 1, 3'd1);
        for (int i = 0; i < 6; i++) step("s02_seek", 1, 0, 0, 3'd1);
        step("s02_done", 0, 1, 0, 3'd1);
        step("s02_idle", 0, 0, 0, 3'd1);
        step("s02_idle2", 0, 0, 0, 3'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
